// File: rtl/led_pwm_core_if.sv
// IO interconnect slave port bundle for the LED controller.
// Single-cycle read/write strobes; read data returns one cycle after rd_en.
interface led_pwm_core_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output rd_en, output wr_en, output address, output wr_data, input rd_data);
  modport slave  (input rd_en, input wr_en, input address, input wr_data, output rd_data);
endinterface

// File: rtl/led_pwm_core.sv
// MMIO LED controller: per-LED static / PWM / blink modes with register readback.
// Optional breathe mode (mode 3) is built only when LED_BREATHE_EN is defined.
module led_pwm_core #(
  parameter int unsigned NUM_LEDS              = 4,
  parameter int unsigned PWM_BITS              = 8,
  parameter int unsigned PRESCALE_BITS         = 16,
  parameter int unsigned BLINK_BITS            = 8,
  parameter logic [31:0] MMIO_LED_BASE_ADDRESS = 32'h4000_0000
) (
  input  logic                clk,
  input  logic                rst,
  led_pwm_core_if.slave       io_bus_s,
  output logic [NUM_LEDS-1:0] led
);

  logic [NUM_LEDS-1:0]      enable;
  logic [2*NUM_LEDS-1:0]    mode;
  logic [PRESCALE_BITS-1:0] prescale;
  logic [BLINK_BITS-1:0]    blink_half;
  logic [PWM_BITS-1:0]      duty [NUM_LEDS];

  logic [PRESCALE_BITS-1:0] pre_cnt;
  logic [PWM_BITS-1:0]      pwm_cnt;
  logic [BLINK_BITS-1:0]    blink_cnt;
  logic                     phase;

  logic                     cs;
  logic [7:0]               offset;
  logic                     wr;
  logic                     rd;
  logic                     wr_prescale;
  logic [NUM_LEDS-1:0]      duty_sel;
  logic [31:0]              rd_mux;
  logic                     tick;
  logic                     period_end;
  logic [NUM_LEDS-1:0]      led_nxt;
  logic                     unused_wr_bits;

  assign cs             = (io_bus_s.address & MMIO_LED_BASE_ADDRESS) == MMIO_LED_BASE_ADDRESS;
  assign offset         = io_bus_s.address[7:0];
  assign wr             = io_bus_s.wr_en & cs;
  assign rd             = io_bus_s.rd_en & cs;
  assign wr_prescale    = wr && (offset == 8'h08);
  assign unused_wr_bits = ^io_bus_s.wr_data;

  always_comb begin
    duty_sel = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      duty_sel[i] = (offset == 8'(16 + 4 * i));
    end
  end

  // Register file
  always_ff @(posedge clk) begin
    if (rst) begin
      enable     <= '0;
      mode       <= '0;
      prescale   <= '0;
      blink_half <= '0;
    end else if (wr) begin
      case (offset)
        8'h00:   enable     <= io_bus_s.wr_data[NUM_LEDS-1:0];
        8'h04:   mode       <= io_bus_s.wr_data[2*NUM_LEDS-1:0];
        8'h08:   prescale   <= io_bus_s.wr_data[PRESCALE_BITS-1:0];
        8'h0C:   blink_half <= io_bus_s.wr_data[BLINK_BITS-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      if (rst) begin
        duty[i] <= '0;
      end else if (wr && duty_sel[i]) begin
        duty[i] <= io_bus_s.wr_data[PWM_BITS-1:0];
      end
    end
  end

  // Readback samples the pre-write value, so a same-cycle read/write returns the old contents
  always_comb begin
    rd_mux = '0;
    case (offset)
      8'h00:   rd_mux[NUM_LEDS-1:0]      = enable;
      8'h04:   rd_mux[2*NUM_LEDS-1:0]    = mode;
      8'h08:   rd_mux[PRESCALE_BITS-1:0] = prescale;
      8'h0C:   rd_mux[BLINK_BITS-1:0]    = blink_half;
      default: begin
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
          if (duty_sel[i]) rd_mux[PWM_BITS-1:0] = duty[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !rd) io_bus_s.rd_data <= '0;
    else            io_bus_s.rd_data <= rd_mux;
  end

  // Timebase: prescaler -> PWM counter -> blink half-period counter
  assign tick       = (pre_cnt == prescale);
  assign period_end = tick && (pwm_cnt == '1);

  always_ff @(posedge clk) begin
    if (rst || wr_prescale) begin
      pre_cnt   <= '0;
      pwm_cnt   <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRESCALE_BITS'(1);
      if (tick) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (period_end) begin
        if (blink_cnt == blink_half) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + BLINK_BITS'(1);
        end
      end
    end
  end

`ifdef LED_BREATHE_EN
  logic [PWM_BITS-1:0] bre_lvl [NUM_LEDS];
  logic [NUM_LEDS-1:0] bre_dir;

  // Direction flips as the endpoint is stepped onto, so the sweep is 0..max..0 with no repeats
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      if (rst || (mode[2*i +: 2] != 2'd3)) begin
        bre_lvl[i] <= '0;
        bre_dir[i] <= 1'b0;
      end else if (period_end) begin
        if (!bre_dir[i]) begin
          bre_lvl[i] <= bre_lvl[i] + PWM_BITS'(1);
          if (bre_lvl[i] == {{(PWM_BITS-1){1'b1}}, 1'b0}) bre_dir[i] <= 1'b1;
        end else begin
          bre_lvl[i] <= bre_lvl[i] - PWM_BITS'(1);
          if (bre_lvl[i] == PWM_BITS'(1)) bre_dir[i] <= 1'b0;
        end
      end
    end
  end
`endif

  always_comb begin
    led_nxt = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      if (enable[i]) begin
        case (mode[2*i +: 2])
          2'd0:    led_nxt[i] = 1'b1;
          2'd1:    led_nxt[i] = (pwm_cnt < duty[i]);
          2'd2:    led_nxt[i] = phase && (pwm_cnt < duty[i]);
`ifdef LED_BREATHE_EN
          default: led_nxt[i] = (pwm_cnt < bre_lvl[i]);
`else
          default: led_nxt[i] = 1'b0;
`endif
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) led <= '0;
    else     led <= led_nxt;
  end

endmodule

// File: tb/tb_led_pwm_core.sv
// Self-checking bench for led_pwm_core: register table, PWM/blink waveforms, reset, mode 3.
// Read results are checked through an expected-value queue popped when rd_data is valid.
module tb_led_pwm_core;
  localparam int unsigned NUM_LEDS = 4;
  localparam logic [31:0] BASE     = 32'h4000_0000;

  logic                clk = 1'b0;
  logic                rst;
  logic [NUM_LEDS-1:0] led;

  led_pwm_core_if bus ();

  led_pwm_core #(
    .NUM_LEDS             (NUM_LEDS),
    .PWM_BITS             (8),
    .PRESCALE_BITS        (16),
    .BLINK_BITS           (8),
    .MMIO_LED_BASE_ADDRESS(BASE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .io_bus_s(bus),
    .led     (led)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic        rd_q = 1'b0;
  logic        idle_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) rd_q <= bus.rd_en;

  // Scoreboard consumer: a read strobe last cycle means rd_data must match the queue head
  always @(negedge clk) begin
    if (rd_q) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", bus.rd_data, 32'h0);
      end else begin
        check("rd_data", bus.rd_data, exp_q.pop_front());
      end
    end else if (idle_chk) begin
      check("rd_idle_zero", bus.rd_data, 32'h0);
    end
  end

  task automatic bus_cycle(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp);
    @(negedge clk);
    bus.rd_en   = rd;
    bus.wr_en   = wr;
    bus.address = addr;
    bus.wr_data = data;
    if (rd) exp_q.push_back(exp);
    @(negedge clk);
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus_cycle(1'b0, 1'b1, addr, data, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    bus_cycle(1'b1, 1'b0, addr, 32'h0, exp);
  endtask

  task automatic count_hi(input int n, output int hi, output int other);
    hi = 0;
    other = 0;
    repeat (n) begin
      @(negedge clk);
      if (led[0]) hi++;
      if (led[NUM_LEDS-1:1] != '0) other++;
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, other, mism, first_bad;
    int duties[4];

    vt[0]  = '{1'b1, BASE + 32'h00, 32'hFFFF_FFFF, BASE + 32'h00, 32'h0000_000F};
    vt[1]  = '{1'b1, BASE + 32'h04, 32'hFFFF_FFE4, BASE + 32'h04, 32'h0000_00E4};
    vt[2]  = '{1'b1, BASE + 32'h08, 32'h0001_2345, BASE + 32'h08, 32'h0000_2345};
    vt[3]  = '{1'b1, BASE + 32'h0C, 32'h0000_01AB, BASE + 32'h0C, 32'h0000_00AB};
    vt[4]  = '{1'b1, BASE + 32'h10, 32'h0000_0111, BASE + 32'h10, 32'h0000_0011};
    vt[5]  = '{1'b1, BASE + 32'h14, 32'h0000_0022, BASE + 32'h14, 32'h0000_0022};
    vt[6]  = '{1'b1, BASE + 32'h18, 32'h0000_0133, BASE + 32'h18, 32'h0000_0033};
    vt[7]  = '{1'b1, BASE + 32'h1C, 32'hFFFF_FF44, BASE + 32'h1C, 32'h0000_0044};
    vt[8]  = '{1'b1, BASE + 32'h40, 32'h0000_005A, BASE + 32'h40, 32'h0000_0000};
    vt[9]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, BASE + 32'h00, 32'h0000_000F};
    vt[10] = '{1'b1, 32'h0000_0010, 32'h0000_0000, BASE + 32'h10, 32'h0000_0011};
    vt[11] = '{1'b1, BASE + 32'h11, 32'h0000_00FF, BASE + 32'h10, 32'h0000_0011};
    vt[12] = '{1'b1, BASE + 32'h20, 32'h0000_00FF, BASE + 32'h20, 32'h0000_0000};
    vt[13] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vt[14] = '{1'b1, 32'h3FFF_FF08, 32'h0000_0001, BASE + 32'h08, 32'h0000_2345};
    vt[15] = '{1'b1, 32'hC000_0008, 32'h0000_0007, BASE + 32'h08, 32'h0000_0007};

    rst         = 1'b1;
    bus.rd_en   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.address = '0;
    bus.wr_data = '0;
    repeat (3) @(negedge clk);
    check("reset_led", 32'(led), 32'h0);
    check("reset_rd_data", bus.rd_data, 32'h0);
    rst      = 1'b0;
    idle_chk = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (vt[i].wr) wr(vt[i].waddr, vt[i].wdata);
      rd(vt[i].raddr, vt[i].exp);
    end

    // Same-cycle read and write of ENABLE: read sees the old value
    bus_cycle(1'b1, 1'b1, BASE + 32'h00, 32'h3, 32'hF);
    rd(BASE + 32'h00, 32'h3);

    // Static mode, one-cycle output latency after the ENABLE write
    wr(BASE + 32'h04, 32'h0);
    wr(BASE + 32'h00, 32'hF);
    check("static_led_latency", 32'(led), 32'h3);
    @(negedge clk);
    check("static_led_all_on", 32'(led), 32'hF);
    rd(BASE + 32'h00, 32'hF);

    // PWM duty sweep at PRESCALE=0
    wr(BASE + 32'h08, 32'h0);
    wr(BASE + 32'h04, 32'h1);
    wr(BASE + 32'h00, 32'h1);
    duties = '{0, 1, 64, 255};
    foreach (duties[k]) begin
      wr(BASE + 32'h10, 32'(duties[k]));
      repeat (2) @(negedge clk);
      count_hi(256, hi, other);
      check("pwm_high_count", 32'(hi), 32'(duties[k]));
      check("pwm_disabled_leds", 32'(other), 32'h0);
    end

    // PRESCALE=1 halves the tick rate: 128 of 512 cycles at duty 64
    wr(BASE + 32'h10, 32'd64);
    wr(BASE + 32'h08, 32'h1);
    repeat (2) @(negedge clk);
    count_hi(512, hi, other);
    check("pwm_prescale1_count", 32'(hi), 32'd128);

    // Blink: the PRESCALE write aligns all counters to zero at the write edge
    wr(BASE + 32'h04, 32'h2);
    wr(BASE + 32'h10, 32'd255);
    wr(BASE + 32'h0C, 32'h1);
    wr(BASE + 32'h08, 32'h0);
    mism = 0;
    first_bad = -1;
    for (int k = 1; k <= 800; k++) begin
      logic exp_led;
      @(negedge clk);
      exp_led = ((k - 1) >= 512) && ((k - 1) < 1024) && (((k - 1) % 256) != 255);
      if (led[0] !== exp_led) begin
        mism++;
        if (first_bad < 0) first_bad = k;
      end
    end
    check("blink_waveform_mismatches", 32'(mism), 32'h0);
    if (mism != 0) $display("first blink divergence at cycle %0d", first_bad);
    check("blink_led_before_reset", 32'(led), 32'h1);

    // Reset mid-blink
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_led", 32'(led), 32'h0);
    check("midreset_rd_data", bus.rd_data, 32'h0);
    for (int a = 0; a < 32; a += 4) rd(BASE + 32'(a), 32'h0);
    count_hi(20, hi, other);
    check("post_reset_led_dark", 32'(hi + other), 32'h0);

    // Mode 3
    wr(BASE + 32'h04, 32'h3);
    wr(BASE + 32'h00, 32'h1);
    rd(BASE + 32'h04, 32'h3);
    count_hi(600, hi, other);
`ifdef LED_BREATHE_EN
    check("breathe_active", 32'(hi > 0 && hi < 600), 32'h1);
`else
    check("mode3_dark", 32'(hi), 32'h0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
